// File: rtl/pipelined_adder_subtractor_if.sv
// Handshake and operand/result bundle for pipelined_adder_subtractor.
// The master drives operands and consumes results; the slave is the adder.
interface pipelined_adder_subtractor_if #(
  parameter int unsigned WIDTH = 32
);
  logic             In_Valid_DI;
  logic             In_Ready_DO;
  logic [WIDTH-1:0] A_DI;
  logic [WIDTH-1:0] B_DI;
  logic             C_DI;
  logic             Sub_DI;
  logic             Out_Valid_DO;
  logic             Out_Ready_DI;
  logic [WIDTH-1:0] S_DO;
  logic             C_DO;
  logic             V_DO;

  modport master (
    output In_Valid_DI, A_DI, B_DI, C_DI, Sub_DI, Out_Ready_DI,
    input  In_Ready_DO, Out_Valid_DO, S_DO, C_DO, V_DO
  );

  modport slave (
    input  In_Valid_DI, A_DI, B_DI, C_DI, Sub_DI, Out_Ready_DI,
    output In_Ready_DO, Out_Valid_DO, S_DO, C_DO, V_DO
  );
endinterface

// File: rtl/pipelined_adder_subtractor.sv
// WIDTH-bit adder/subtractor with the carry chain cut into STAGES registered
// chunks of WIDTH/STAGES bits. Each stage carries its beat's operands, the
// finished low sum bits and the chunk carry; valid/ready on both ends with
// full backpressure and bubble collapsing.
module pipelined_adder_subtractor #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input logic                   Clk_CI,
  input logic                   Rst_RI,
  pipelined_adder_subtractor_if.slave bus
);

  localparam int unsigned CW = WIDTH / STAGES;

  logic [STAGES-1:0] valid_q, valid_d;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic [STAGES-1:0] c_q, c_d;
  logic              v_q, v_d;

  // Per-stage source view: stage 0 reads the input port, stage k reads stage k-1.
  logic [STAGES-1:0] src_valid;
  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_s [STAGES];
  logic [STAGES-1:0] src_c;

  logic [STAGES-1:0] load;
  logic              rdy;
  logic [CW:0]       sum;

  function automatic logic [CW:0] chunk_add(input logic [CW-1:0] a,
                                            input logic [CW-1:0] b,
                                            input logic          cin);
    return {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
  endfunction

  // Ready chain, walked from the output back to the input: a stage loads
  // when it is empty or its own contents leave this cycle.
  always_comb begin
    load = '0;
    rdy  = bus.Out_Ready_DI;
    for (int unsigned i = 0; i < STAGES; i++) begin
      load[STAGES-1-i] = !valid_q[STAGES-1-i] || rdy;
      rdy              = load[STAGES-1-i];
    end
  end

  // Operand source for each stage; subtraction becomes A + ~B + 1 at entry.
  always_comb begin
    src_valid[0] = bus.In_Valid_DI;
    src_a[0]     = bus.A_DI;
    src_b[0]     = bus.Sub_DI ? ~bus.B_DI : bus.B_DI;
    src_s[0]     = '0;
    src_c[0]     = bus.Sub_DI | bus.C_DI;
    for (int unsigned k = 1; k < STAGES; k++) begin
      src_valid[k] = valid_q[k-1];
      src_a[k]     = a_q[k-1];
      src_b[k]     = b_q[k-1];
      src_s[k]     = s_q[k-1];
      src_c[k]     = c_q[k-1];
    end
  end

  // Chunk adders and next-state for every stage; the last stage also forms
  // V from the carry into and out of the MSB.
  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    c_d     = c_q;
    v_d     = v_q;
    sum     = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      sum = chunk_add(src_a[k][k*CW +: CW], src_b[k][k*CW +: CW], src_c[k]);
      if (load[k]) begin
        valid_d[k] = src_valid[k];
        if (src_valid[k]) begin
          a_d[k]              = src_a[k];
          b_d[k]              = src_b[k];
          s_d[k]              = src_s[k];
          s_d[k][k*CW +: CW]  = sum[CW-1:0];
          c_d[k]              = sum[CW];
          if (k == STAGES-1) begin
            // carry into MSB = a ^ b ^ sum at that bit
            v_d = sum[CW] ^ sum[CW-1] ^ src_a[k][WIDTH-1] ^ src_b[k][WIDTH-1];
          end
        end
      end
    end
  end

  // Stage registers; reset drops every beat in flight.
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      valid_q <= '0;
      c_q     <= '0;
      v_q     <= 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      c_q     <= c_d;
      v_q     <= v_d;
    end
  end

  assign bus.In_Ready_DO  = load[0] & ~Rst_RI;
  assign bus.Out_Valid_DO = valid_q[STAGES-1];
  assign bus.S_DO         = s_q[STAGES-1];
  assign bus.C_DO         = c_q[STAGES-1];
  assign bus.V_DO         = v_q;

endmodule
